// File: rtl/drum_pkg.sv
// Shared types and constants for the drum mesh column sequencer.
// Optional build macro: DRUM_AUDIO_SCALE_EN (sample scaling with saturation).
package drum_pkg;

  typedef logic signed [17:0] node_t;

  localparam int N_ROWS_DEF     = 30;
  localparam int CENTER_ROW_DEF = 15;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    FETCH,
    CALC,
    WRITE
  } col_state_t;

  localparam node_t SAT_MAX = 18'sh1FFFF;
  localparam node_t SAT_MIN = 18'sh20000;

endpackage

// File: rtl/drum_sample_port.sv
// Audio sample register with valid/ready handshake and overrun flag.
// Optional build macro: DRUM_AUDIO_SCALE_EN (x4 scaling, saturated).
module drum_sample_port
  import drum_pkg::*;
#(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         idle,
  input  logic         capture,
  input  logic         publish,
  input  logic [W-1:0] next_val,
  input  logic         sample_ready,
  output logic         accept,
  output logic [W-1:0] sample,
  output logic         sample_valid,
  output logic         overrun
);

  logic [W-1:0] cap_val;

`ifdef DRUM_AUDIO_SCALE_EN
  logic [W+1:0] wide;

  // Top three bits must agree, otherwise the shift overflowed.
  always_comb begin
    wide    = {{2{next_val[W-1]}}, next_val} << 2;
    cap_val = wide[W-1:0];
    if (!(wide[W+1:W-1] == 3'b000 ||
          wide[W+1:W-1] == 3'b111)) begin
      if (next_val[W-1])
        cap_val = W'(SAT_MIN);
      else
        cap_val = W'(SAT_MAX);
    end
  end
`else
  assign cap_val = next_val;
`endif

  // Valid is judged before this cycle's acceptance takes effect.
  assign accept = start && idle && !sample_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (capture)
        sample <= cap_val;
      if (publish)
        sample_valid <= 1'b1;
      else if (sample_valid && sample_ready)
        sample_valid <= 1'b0;
      if (start && idle && sample_valid)
        overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/drum_column_sequencer.sv
// Sweeps one drum mesh column per time-step through the node update unit.
// Optional build macro: DRUM_AUDIO_SCALE_EN (scaled audio sample).
module drum_column_sequencer
  import drum_pkg::*;
#(
  parameter int N_ROWS     = N_ROWS_DEF,
  parameter int CENTER_ROW = CENTER_ROW_DEF,
  parameter int W          = 18,
  parameter int AW         = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rd_addr,
  input  logic [W-1:0]  curr_rd_data,
  input  logic [W-1:0]  prev_rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [W-1:0]  curr_wr_data,
  output logic [W-1:0]  prev_wr_data,
  output logic [W-1:0]  node_curr,
  output logic [W-1:0]  node_prev,
  output logic [W-1:0]  node_up,
  output logic [W-1:0]  node_down,
  input  logic [W-1:0]  node_next,
  output logic [W-1:0]  col_curr,
  output logic [W-1:0]  sample,
  output logic          sample_valid,
  input  logic          sample_ready,
  output logic          overrun
);

  localparam logic [AW-1:0] LAST = AW'(N_ROWS - 1);
  localparam logic [AW-1:0] CTR  = AW'(CENTER_ROW);

  col_state_t    state, state_nx;
  logic [AW-1:0] r;
  logic [AW:0]   r2;
  logic [W-1:0]  here_curr, here_prev;
  logic [W-1:0]  up, up_prev, down;
  logic          last, in_write, idle;
  logic          accept, capture, sweep_end;

  assign last      = (r == LAST);
  assign in_write  = (state == WRITE);
  assign idle      = (state == IDLE);
  assign sweep_end = in_write && last;
  assign capture   = in_write && (r == CTR);
  assign r2        = {1'b0, r} + (AW+1)'(2);

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = PRIME;
      PRIME:   state_nx = FETCH;
      FETCH:   state_nx = CALC;
      CALC:    state_nx = WRITE;
      WRITE:   state_nx = last ? IDLE : FETCH;
      default: state_nx = IDLE;
    endcase
  end

  // rd_addr idles at 0 so row-0 data is already in flight at start.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_addr   <= '0;
      r         <= '0;
      here_curr <= '0;
      here_prev <= '0;
      up        <= '0;
      up_prev   <= '0;
      down      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            busy    <= 1'b1;
            rd_addr <= '0;
          end
        end
        PRIME: begin
          here_curr <= curr_rd_data;
          here_prev <= prev_rd_data;
          down      <= '0;
          r         <= '0;
          rd_addr   <= AW'(1);
        end
        FETCH: ;
        CALC: begin
          up      <= last ? '0 : curr_rd_data;
          up_prev <= prev_rd_data;
        end
        WRITE: begin
          down      <= here_curr;
          here_curr <= up;
          here_prev <= up_prev;
          if (last) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            rd_addr <= '0;
          end else begin
            r <= r + AW'(1);
            if (r2 < (AW+1)'(N_ROWS))
              rd_addr <= r2[AW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_en        = in_write;
  assign wr_addr      = in_write ? r : '0;
  assign curr_wr_data = in_write ? node_next : '0;
  assign prev_wr_data = in_write ? here_curr : '0;

  assign node_curr = here_curr;
  assign node_prev = here_prev;
  assign node_up   = up;
  assign node_down = down;
  assign col_curr  = here_curr;

  drum_sample_port #(
    .W(W)
  ) u_sample (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .idle         (idle),
    .capture      (capture),
    .publish      (sweep_end),
    .next_val     (node_next),
    .sample_ready (sample_ready),
    .accept       (accept),
    .sample       (sample),
    .sample_valid (sample_valid),
    .overrun      (overrun)
  );

endmodule

// File: tb/tb_drum_column_sequencer.sv
// Directed bench: 4-row column, next = up + down update unit.
// Honours DRUM_AUDIO_SCALE_EN for the expected audio sample.
module tb_drum_column_sequencer;

  localparam int W  = 18;
  localparam int AW = 5;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [W-1:0]  curr_rd_data, prev_rd_data;
  logic          wr_en;
  logic [W-1:0]  curr_wr_data, prev_wr_data;
  logic [W-1:0]  node_curr, node_prev;
  logic [W-1:0]  node_up, node_down, node_next;
  logic [W-1:0]  col_curr, sample;
  logic          sample_valid;
  logic          sample_ready = 1'b0;
  logic          overrun;

  logic [W-1:0] mem_curr [NR];
  logic [W-1:0] mem_prev [NR];
  int wr_count = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  drum_column_sequencer #(
    .N_ROWS(NR), .CENTER_ROW(1), .W(W), .AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .rd_addr(rd_addr),
    .curr_rd_data(curr_rd_data),
    .prev_rd_data(prev_rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .curr_wr_data(curr_wr_data),
    .prev_wr_data(prev_wr_data),
    .node_curr(node_curr), .node_prev(node_prev),
    .node_up(node_up), .node_down(node_down),
    .node_next(node_next), .col_curr(col_curr),
    .sample(sample), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overrun(overrun)
  );

  assign node_next = node_up + node_down;

  always @(posedge clk) begin
    curr_rd_data <= mem_curr[rd_addr[1:0]];
    prev_rd_data <= mem_prev[rd_addr[1:0]];
    if (wr_en) begin
      mem_curr[wr_addr[1:0]] <= curr_wr_data;
      mem_prev[wr_addr[1:0]] <= prev_wr_data;
      wr_count++;
    end
  end

  task automatic load_mem(input logic [W-1:0] c0, c1, c2, c3);
    mem_curr[0] = c0; mem_curr[1] = c1;
    mem_curr[2] = c2; mem_curr[3] = c3;
    for (int i = 0; i < NR; i++) mem_prev[i] = '0;
  endtask

  // Start pulse, then cycles until done (or -1 on timeout).
  task automatic run_sweep(output int lat);
    int cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    lat = done ? cyc : -1;
  endtask

  task automatic release_sample;
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, wr_en, sample_valid, overrun} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b want=00000",
               {busy, done, wr_en, sample_valid, overrun});
    end
    checks++;
    if (rd_addr !== '0 || wr_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr got rd=%0d wr=%0d want 0 0", rd_addr, wr_addr);
    end
    checks++;
    if ({node_curr, node_prev, node_up, node_down, col_curr, sample} !== '0) begin
      errors++;
      $display("FAIL reset_data got curr=%h prev=%h up=%h dn=%h col=%h smp=%h want 0",
               node_curr, node_prev, node_up, node_down, col_curr, sample);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweep;
    int lat;
    logic [W-1:0] exp_c [NR];
    exp_c[0] = 18'h200; exp_c[1] = 18'h400;
    exp_c[2] = 18'h600; exp_c[3] = 18'h300;
    load_mem(18'h100, 18'h200, 18'h300, 18'h400);
    run_sweep(lat);
    checks++;
    if (lat !== 14) begin
      errors++;
      $display("FAIL sweep_latency got=%0d want=14", lat);
    end
    checks++;
    if (busy !== 1'b0 || sample_valid !== 1'b1) begin
      errors++;
      $display("FAIL sweep_end got busy=%b valid=%b want 0 1", busy, sample_valid);
    end
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (mem_curr[i] !== exp_c[i]) begin
        errors++;
        $display("FAIL sweep_curr[%0d] got=%h want=%h", i, mem_curr[i], exp_c[i]);
      end
      checks++;
      if (mem_prev[i] !== 18'(18'h100 * (i + 1))) begin
        errors++;
        $display("FAIL sweep_prev[%0d] got=%h want=%h",
                 i, mem_prev[i], 18'(18'h100 * (i + 1)));
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse got=%b want=0", done);
    end
  endtask

  task automatic test_hold;
    int bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (sample_valid !== 1'b1 || sample !== 18'h400) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sample_hold got %0d bad cycles, sample=%h want 0 and 400",
               bad, sample);
    end
  endtask

  task automatic test_overrun;
    int w0 = wr_count;
    int bsy = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy) bsy++;
      @(negedge clk);
    end
    checks++;
    if (wr_count != w0 || bsy != 0) begin
      errors++;
      $display("FAIL overrun_drop got writes=%0d busy_cycles=%0d want 0 0",
               wr_count - w0, bsy);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got=%b want=1", overrun);
    end
  endtask

  task automatic test_handshake;
    sample_ready = 1'b1;
    checks++;
    if (sample_valid !== 1'b1) begin
      errors++;
      $display("FAIL hs_before got=%b want=1", sample_valid);
    end
    @(negedge clk);
    sample_ready = 1'b0;
    checks++;
    if (sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL hs_clear got=%b want=0", sample_valid);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky got=%b want=1", overrun);
    end
  endtask

  task automatic test_back_to_back;
    int first = -1;
    int n = 0;
    load_mem(18'h100, 18'h200, 18'h300, 18'h400);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (cyc == 5) start = 1'b1;
      if (cyc == 6) start = 1'b0;
      if (done) begin
        n++;
        if (first < 0) first = cyc;
      end
      @(negedge clk);
    end
    checks++;
    if (n != 1 || first != 14) begin
      errors++;
      $display("FAIL mid_start got done_count=%0d at=%0d want 1 at 14", n, first);
    end
    release_sample();
  endtask

  task automatic test_reset_mid;
    int lat;
    load_mem(18'h100, 18'h200, 18'h300, 18'h400);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got wr_en=%b busy=%b want 1 1", wr_en, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({wr_en, busy, sample_valid, overrun} !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset got=%b want=0000",
               {wr_en, busy, sample_valid, overrun});
    end
    reset = 1'b0;
    @(negedge clk);
    load_mem(18'h100, 18'h200, 18'h300, 18'h400);
    run_sweep(lat);
    checks++;
    if (lat !== 14 || mem_curr[3] !== 18'h300 || sample !== 18'h400) begin
      errors++;
      $display("FAIL mid_fresh got lat=%0d c3=%h smp=%h want 14 300 400",
               lat, mem_curr[3], sample);
    end
    @(negedge clk);
    release_sample();
  endtask

  task automatic test_scale;
    int lat;
    logic [W-1:0] exp1, exp2;
`ifdef DRUM_AUDIO_SCALE_EN
    exp1 = 18'h1FFFF;
    exp2 = 18'h04000;
`else
    exp1 = 18'h0C000;
    exp2 = 18'h01000;
`endif
    load_mem(18'h4000, 18'h0, 18'h8000, 18'h0);
    run_sweep(lat);
    checks++;
    if (lat !== 14 || sample !== exp1) begin
      errors++;
      $display("FAIL scale_sat got lat=%0d smp=%h want 14 %h", lat, sample, exp1);
    end
    @(negedge clk);
    release_sample();
    load_mem(18'h800, 18'h0, 18'h800, 18'h0);
    run_sweep(lat);
    checks++;
    if (lat !== 14 || sample !== exp2) begin
      errors++;
      $display("FAIL scale_lin got lat=%0d smp=%h want 14 %h", lat, sample, exp2);
    end
    @(negedge clk);
    release_sample();
  endtask

  initial begin
    load_mem('0, '0, '0, '0);
    test_reset();
    test_sweep();
    test_hold();
    test_overrun();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_scale();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/drum_column_sequencer.md
Name: drum_column_sequencer

Overview:
- Drives one column of the drum mesh through a single time-step. It reads each node's current and previous displacement from per-column state RAMs and presents them, with neighbour values, to the external per-node update unit.
- It then takes the unit's `next` result, writes the rotated state back, and hands the centre-node displacement to the audio path over a valid/ready handshake.
- It sits between the column state RAMs and the node update datapath. One instance runs per column, and all columns run in lockstep from a common `start` strobe.

Parameters:
- N_ROWS, 30, nodes per column (minimum 2).
- CENTER_ROW, 15, row whose new value becomes the audio sample (0..N_ROWS-1).
- W, 18, data width; signed 1.17 two's complement.
- AW, 5, RAM address width; must satisfy 2^AW >= N_ROWS.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous, active-high.
- start, in, 1, one-cycle strobe; begins one time-step sweep.
- busy, out, 1, high from the cycle after an accepted start until done.
- done, out, 1, one-cycle pulse when the last row is written.
- rd_addr, out, AW, RAM read address; both RAMs share it; read latency is 1 cycle.
- curr_rd_data, in, W, current-state RAM read data.
- prev_rd_data, in, W, previous-state RAM read data.
- wr_en, out, 1, write strobe for both RAMs.
- wr_addr, out, AW, write address.
- curr_wr_data, out, W, new current value (= node next).
- prev_wr_data, out, W, new previous value (= old current).
- node_curr, out, W, to update unit: current value of the active row.
- node_prev, out, W, to update unit: previous value of the active row.
- node_up, out, W, to update unit: value of row r+1.
- node_down, out, W, to update unit: value of row r-1.
- node_next, in, W, from update unit; combinational result of the node_* outputs.
- col_curr, out, W, this column's active-row current value, exported to neighbour columns.
- sample, out, W, audio sample.
- sample_valid, out, 1, sample handshake valid.
- sample_ready, in, 1, sample handshake ready.
- overrun, out, 1, sticky flag; set when a start is dropped.

Behaviour:
- Reset values:
  - busy=0, done=0, wr_en=0.
  - rd_addr=0, wr_addr=0.
  - All node_* outputs = 0; col_curr=0.
  - sample=0, sample_valid=0, overrun=0.
  - State = IDLE; row counter = 0.
- States: IDLE, PRIME, FETCH, CALC, WRITE.
- IDLE:
  - If start=1 and sample_valid=0: go to PRIME, set busy, rd_addr=0.
  - If start=1 and sample_valid=1: remain in IDLE and set overrun (sticky until reset).
  - start while busy is ignored and does not set overrun.
- PRIME (1 cycle):
  - Row-0 data returns.
  - Latch it as here_curr/here_prev; down=0; r=0.
  - Go to FETCH.
- FETCH:
  - rd_addr=r+1 when r<N_ROWS-1.
  - Go to CALC.
- CALC:
  - Latch up=curr_rd_data and up_prev=prev_rd_data.
  - For r=N_ROWS-1, up is forced to 0 (fixed boundary).
  - node_* outputs are driven from registers: node_curr=here_curr, node_prev=here_prev, node_up=up, node_down=down.
  - Go to WRITE.
- WRITE:
  - wr_en=1, wr_addr=r, curr_wr_data=node_next, prev_wr_data=here_curr.
  - If r==CENTER_ROW, capture node_next into the sample register.
  - Shift the window: down<=here_curr (the old value, not next), here_curr<=up, here_prev<=up_prev.
  - If r==N_ROWS-1: pulse done, clear busy, go to IDLE, assert sample_valid.
  - Otherwise r<=r+1 and go to FETCH.
- Row 0 uses down=0.
- col_curr = here_curr throughout.
- Sweep latency: start to done = 2 + 3*N_ROWS cycles. Columns stay aligned because the timing is data-independent.
- Handshake:
  - sample_valid stays high, and sample stays stable, until the cycle in which sample_valid && sample_ready; it clears on the next edge.
  - Acceptance in the same cycle as a new start: the start is dropped and overrun is set (valid is sampled before acceptance).
- No arithmetic is performed here; values pass through with no saturation, except under the optional feature.
- Reset mid-sweep: abort immediately, wr_en=0 on the next cycle, and return to reset values. Partially written RAM contents are left as they are.

Optional Feature:
- DRUM_AUDIO_SCALE_EN:
  - Defined: the captured sample is node_next <<< 2, saturated to 0x1FFFF / 0x20000.
  - Undefined: the sample is node_next unmodified.

Decomposition:
- Shared package drum_pkg:
  - typedef node_t (signed [17:0]).
  - Constants N_ROWS_DEF=30 and CENTER_ROW_DEF=15.
  - State enum col_state_t.
  - Saturation limits SAT_MAX and SAT_MIN.
- One natural sub-module, drum_sample_port: the sample register, valid/ready logic, optional scaling, and overrun flag.

Test Plan:
- N_ROWS=4; RAM curr = {0x100, 0x200, 0x300, 0x400}, prev=0; update unit modelled as next = up + down. Pulse start → done 14 cycles later; RAM curr = {0x200, 0x400, 0x600, 0x300}; prev = old curr.
- Same setup, CENTER_ROW=1, sample_ready=0 → sample_valid=1 with sample=0x400, held for 20 cycles. Raise ready → valid clears the next cycle.
- Second start while sample_valid=1 → no RAM writes, busy stays 0, overrun=1 and stays 1.
- start pulsed again mid-sweep → ignored; done occurs exactly once, at the original cycle.
- Assert reset at cycle 6 of a sweep → the next cycle shows wr_en=0, busy=0, sample_valid=0; a fresh start completes normally.
- DRUM_AUDIO_SCALE_EN defined, centre next=0x0C000 → sample=0x1FFFF; next=0x01000 → sample=0x04000.
